// File: rtl/sensor_sample_fifo.sv
// -----------------------------------------------------------------------------
// sensor_sample_fifo
//
// Purpose
//   Captures each {remote, local} temperature pair from the TMP421 sensor
//   application on the rising edge of its CpuIntr line and queues it in a
//   first-word-fall-through FIFO polled by the CPU.
//   Measurements that arrive between CPU polls are therefore not lost.
//   A capture that finds the FIFO full raises a sticky overflow flag.
//   An optional fill-level watermark interrupt is available.
//
// Configuration
//   SENSOR_FIFO_WATERMARK_IRQ_EN
//     Defined:   WatermarkIrq_o is a register that is high while the fill
//                level is at or above a non-zero Watermark_i.
//     Undefined: WatermarkIrq_o is tied low and Watermark_i is ignored.
//
// Parameters
//   AddrWidth  FIFO address bits; Depth = 2**AddrWidth entries
//   DataWidth  width of one sensor value; an entry is 2*DataWidth wide
//
// Ports
//   Clk_i            in   clock, rising edge
//   Reset_i          in   asynchronous active-high reset
//   Enable_i         in   capture enable; low flushes and holds the FIFO empty
//   SensorIntr_i     in   sensor CpuIntr; a rising edge means a new pair is valid
//   SensorValueL_i   in   local temperature
//   SensorValueR_i   in   remote temperature
//   RdNext_i         in   CPU pop strobe, one entry per high cycle
//   Data_o           out  head entry {R,L}, or zero when empty
//   Empty_o          out  FIFO empty
//   Full_o           out  FIFO full
//   Count_o          out  number of stored entries, 0..Depth
//   Overflow_o       out  sticky flag: a capture was dropped because the FIFO was full
//   ClearOverflow_i  in   synchronous clear of Overflow_o
//   Watermark_i      in   watermark level
//   WatermarkIrq_o   out  level interrupt: fill level reached the watermark
//
// Handshake
//   A write is attempted on a rising edge of SensorIntr_i while Enable_i is high.
//   A pop happens on every cycle in which RdNext_i is high and Empty_o is low.
//   A pop while empty is ignored.
//   Both take effect on the next rising edge of Clk_i.
//   Data_o always shows the head entry without a read latency.
// -----------------------------------------------------------------------------
module sensor_sample_fifo #(
   parameter int AddrWidth = 3,
   parameter int DataWidth = 16
) (
   input  logic                   Clk_i,
   input  logic                   Reset_i,
   input  logic                   Enable_i,
   input  logic                   SensorIntr_i,
   input  logic [DataWidth-1:0]   SensorValueL_i,
   input  logic [DataWidth-1:0]   SensorValueR_i,
   input  logic                   RdNext_i,
   output logic [2*DataWidth-1:0] Data_o,
   output logic                   Empty_o,
   output logic                   Full_o,
   output logic [AddrWidth:0]     Count_o,
   output logic                   Overflow_o,
   input  logic                   ClearOverflow_i,
   input  logic [AddrWidth:0]     Watermark_i,
   output logic                   WatermarkIrq_o
);

   localparam int                 Depth    = 2 ** AddrWidth;
   localparam logic [AddrWidth:0] DepthCnt = (AddrWidth + 1)'(Depth);
   localparam logic [AddrWidth:0] CntOne   = (AddrWidth + 1)'(1);

   logic [2*DataWidth-1:0] r_mem [Depth];
   logic [AddrWidth-1:0]   r_wr_ptr;
   logic [AddrWidth-1:0]   r_rd_ptr;
   logic [AddrWidth:0]     r_count;
   logic                   r_intr_dly;
   logic                   r_overflow;

   logic [AddrWidth:0]     w_count_next;
   logic                   w_empty;
   logic                   w_full;
   logic                   w_wr_req;
   logic                   w_wr;
   logic                   w_rd;
   logic                   w_drop;

   // Full and empty come only from the occupancy counter.
   // Pointer equality is therefore never ambiguous.
   assign w_empty  = (r_count == '0);
   assign w_full   = (r_count == DepthCnt);

   // A new sample arrives on a rising edge of the sensor interrupt.
   assign w_wr_req = Enable_i & SensorIntr_i & ~r_intr_dly;
   assign w_rd     = RdNext_i & ~w_empty;

   // When the FIFO is full, a same-cycle pop frees the slot.
   // In that case the write is accepted instead of dropped.
   assign w_wr     = w_wr_req & (~w_full | w_rd);
   assign w_drop   = w_wr_req & w_full & ~w_rd;

   always_comb begin
      w_count_next = r_count;
      if (!Enable_i) begin
         w_count_next = '0;
      end else if (w_wr && !w_rd) begin
         w_count_next = r_count + CntOne;
      end else if (w_rd && !w_wr) begin
         w_count_next = r_count - CntOne;
      end
   end

   // The edge detector keeps tracking while disabled.
   // A level that is already high at re-enable is then not mistaken for a new sample.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         r_intr_dly <= 1'b0;
      end else begin
         r_intr_dly <= SensorIntr_i;
      end
   end

   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
      end else begin
         r_count <= w_count_next;
         if (!Enable_i) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
         end else begin
            if (w_wr) begin
               r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rd) begin
               r_rd_ptr <= r_rd_ptr + 1'b1;
            end
         end
      end
   end

   // A drop sets the overflow flag even when a clear is requested in the same cycle.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         r_overflow <= 1'b0;
      end else if (!Enable_i) begin
         r_overflow <= 1'b0;
      end else if (w_drop) begin
         r_overflow <= 1'b1;
      end else if (ClearOverflow_i) begin
         r_overflow <= 1'b0;
      end
   end

   // The storage has no reset.
   // Data_o is masked to zero while empty, so stale contents are never visible.
   always_ff @(posedge Clk_i) begin
      if (w_wr) begin
         r_mem[r_wr_ptr] <= {SensorValueR_i, SensorValueL_i};
      end
   end

   assign Data_o     = w_empty ? '0 : r_mem[r_rd_ptr];
   assign Empty_o    = w_empty;
   assign Full_o     = w_full;
   assign Count_o    = r_count;
   assign Overflow_o = r_overflow;

`ifdef SENSOR_FIFO_WATERMARK_IRQ_EN
   logic r_wm_irq;

   // The interrupt is computed from the next count.
   // It therefore rises on the same edge that brings Count_o to the level.
   always_ff @(posedge Clk_i or posedge Reset_i) begin
      if (Reset_i) begin
         r_wm_irq <= 1'b0;
      end else begin
         r_wm_irq <= (Watermark_i != '0) && (w_count_next >= Watermark_i);
      end
   end

   assign WatermarkIrq_o = r_wm_irq;
`else
   logic w_unused_watermark;

   assign w_unused_watermark = ^Watermark_i;
   assign WatermarkIrq_o     = 1'b0;
`endif

endmodule

// File: tb/tb_sensor_sample_fifo.sv
module tb_sensor_sample_fifo;

   localparam int AW    = 3;
   localparam int DW    = 16;
   localparam int DEPTH = 8;
   localparam int WM    = 3;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   logic            enable;
   logic            sensor_intr;
   logic [DW-1:0]   value_l;
   logic [DW-1:0]   value_r;
   logic            rd_next;
   logic [2*DW-1:0] data;
   logic            empty;
   logic            full;
   logic [AW:0]     count;
   logic            overflow;
   logic            clear_overflow;
   logic [AW:0]     watermark;
   logic            wm_irq;

   sensor_sample_fifo #(.AddrWidth(AW), .DataWidth(DW)) dut (
      .Clk_i           (clk),
      .Reset_i         (rst),
      .Enable_i        (enable),
      .SensorIntr_i    (sensor_intr),
      .SensorValueL_i  (value_l),
      .SensorValueR_i  (value_r),
      .RdNext_i        (rd_next),
      .Data_o          (data),
      .Empty_o         (empty),
      .Full_o          (full),
      .Count_o         (count),
      .Overflow_o      (overflow),
      .ClearOverflow_i (clear_overflow),
      .Watermark_i     (watermark),
      .WatermarkIrq_o  (wm_irq)
   );

   // ---------------- scoreboard ----------------
   logic [2*DW-1:0] exp_q[$];
   logic            m_ovf;
   int              n_cmp = 0;
   int              n_err = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_irq();
`ifdef SENSOR_FIFO_WATERMARK_IRQ_EN
      return (exp_q.size() >= WM);
`else
      return 1'b0;
`endif
   endfunction

   // Compares all visible outputs against the model.
   // Every field is a separate comparison.
   task automatic check_status(input string tag);
      int sz;
      sz = exp_q.size();
      check({tag, ".count"}, 32'(count), 32'(sz));
      check({tag, ".empty"}, 32'(empty), 32'(sz == 0));
      check({tag, ".full"}, 32'(full), 32'(sz == DEPTH));
      check({tag, ".ovf"}, 32'(overflow), 32'(m_ovf));
      check({tag, ".data"}, 32'(data), (sz == 0) ? 32'h0 : 32'(exp_q[0]));
      check({tag, ".irq"}, 32'(wm_irq), 32'(exp_irq()));
   endtask

   // ---------------- drivers ----------------
   // One sensor pulse, optionally together with a pop in the same cycle.
   task automatic capture(input logic [DW-1:0] r, input logic [DW-1:0] l, input bit with_rd);
      int sz;
      bit rd;
      bit wr;
      @(negedge clk);
      value_r     = r;
      value_l     = l;
      sensor_intr = 1'b1;
      rd_next     = with_rd;
      sz = exp_q.size();
      rd = with_rd && (sz != 0);
      wr = enable && ((sz < DEPTH) || rd);
      if (rd) void'(exp_q.pop_front());
      if (wr) exp_q.push_back({r, l});
      else if (enable) m_ovf = 1'b1;
      @(negedge clk);
      sensor_intr = 1'b0;
      rd_next     = 1'b0;
   endtask

   task automatic pop();
      @(negedge clk);
      rd_next = 1'b1;
      if (exp_q.size() != 0) void'(exp_q.pop_front());
      @(negedge clk);
      rd_next = 1'b0;
   endtask

   task automatic clear_ovf();
      @(negedge clk);
      clear_overflow = 1'b1;
      m_ovf = 1'b0;
      @(negedge clk);
      clear_overflow = 1'b0;
   endtask

   task automatic drain(input string tag);
      while (exp_q.size() != 0) begin
         check_status(tag);
         pop();
      end
      check_status({tag, ".end"});
   endtask

   // ---------------- stimulus ----------------
   initial begin
      rst            = 1'b1;
      enable         = 1'b1;
      sensor_intr    = 1'b0;
      value_l        = '0;
      value_r        = '0;
      rd_next        = 1'b0;
      clear_overflow = 1'b0;
      watermark      = (AW + 1)'(WM);
      m_ovf          = 1'b0;
      repeat (3) @(negedge clk);
      check_status("reset");
      rst = 1'b0;
      @(negedge clk);

      // Three pairs are returned in order.
      capture(16'h1234, 16'h0A0B, 0);
      check_status("t1.c1");
      capture(16'h1235, 16'h0A0C, 0);
      check_status("t1.c2");
      capture(16'h1236, 16'h0A0D, 0);
      check_status("t1.c3");
      check("t1.head", 32'(data), 32'h12340A0B);
      pop();
      check_status("t1.p1");
      check("t1.irq_drop", 32'(wm_irq), 32'h0);
      drain("t1");
      pop();
      check_status("t1.empty_rd");

      // A level held high yields one entry only.
      @(negedge clk);
      value_r     = 16'hBEEF;
      value_l     = 16'h0042;
      sensor_intr = 1'b1;
      exp_q.push_back(32'hBEEF0042);
      repeat (10) @(negedge clk);
      sensor_intr = 1'b0;
      check_status("t2.hold");
      drain("t2");

      // The ninth capture overflows and leaves the head unchanged.
      for (int i = 0; i < DEPTH + 1; i++) begin
         capture(DW'(16'h2000 + i), DW'($urandom_range(0, 16'hFFFF)), 0);
      end
      check_status("t3.full");
      check("t3.ovf", 32'(overflow), 32'h1);
      clear_ovf();
      check_status("t3.clr");

      // When full, a capture with a same-cycle pop is accepted.
      capture(16'h3333, 16'h4444, 1);
      check_status("t4.swap");
      check("t4.cnt8", 32'(count), 32'(DEPTH));
      drain("t4");
      capture(16'h5555, 16'h6666, 1);
      check_status("t4.empty_rw");
      drain("t4b");

      // A one-cycle disable flushes the FIFO.
      // A level that is already high at re-enable is not captured.
      for (int i = 0; i < 4; i++) begin
         capture(DW'($urandom_range(0, 16'hFFFF)), DW'(i), 0);
      end
      check_status("t5.four");
      @(negedge clk);
      enable      = 1'b0;
      sensor_intr = 1'b1;
      exp_q.delete();
      m_ovf = 1'b0;
      @(negedge clk);
      check_status("t5.flush");
      enable = 1'b1;
      repeat (3) @(negedge clk);
      check_status("t5.reen");
      sensor_intr = 1'b0;
      @(negedge clk);

      // The watermark interrupt is checked at each step through check_status.
      for (int i = 0; i < 4; i++) begin
         capture(DW'(16'h7000 + i), DW'(16'h0100 + i), 0);
         check_status("t6.cap");
      end
      pop();
      check_status("t6.pop1");
      pop();
      check_status("t6.pop2");

      // A reset in mid-operation takes effect before the next clock edge.
      capture(16'h9999, 16'h8888, 0);
      @(negedge clk);
      #2;
      rst = 1'b1;
      exp_q.delete();
      m_ovf = 1'b0;
      #1;
      check_status("rst_async");
      @(negedge clk);
      rst = 1'b0;
      capture(16'hABCD, 16'h1357, 0);
      check_status("post_rst");
      drain("post_rst");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout: got running expected finished");
      $fatal(1, "timeout");
   end

endmodule
